// File: rtl/mem_wb_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data-memory req/ack access, branch resolution,
// upstream stall generation and the MEM/WB pipeline register.
module mem_wb_stage #(
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [1:0]        wb_ctlout,
    input  logic              branch,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [DATA_W-1:0] add_result,
    input  logic              zero,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] rdata2out,
    input  logic [REG_W-1:0]  five_bit_muxout,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              pcsrc,
    output logic [DATA_W-1:0] branch_target,
    output logic              mem_err,
    output logic              wb_valid,
    output logic [1:0]        wb_ctl,
    output logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [REG_W-1:0]  wb_write_reg
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic              valid;
        logic [1:0]        ctl;
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] alu;
        logic [REG_W-1:0]  dst;
    } wb_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              req_n, we_n, err_n;
    logic [DATA_W-1:0] addr_n, wdata_n;
    wb_t               wb_q, wb_n;
    logic              memop, acked, timeout;

    assign memop   = in_valid & (memread | memwrite);
    assign acked   = (state == ACCESS) & mem_ack;
    assign timeout = (state == ACCESS) & ~mem_ack & (cnt == CNT_LAST);

    assign stall         = memop & ~acked & ~timeout;
    assign pcsrc         = in_valid & branch & zero;
    assign branch_target = add_result;

    assign wb_valid      = wb_q.valid;
    assign wb_ctl        = wb_q.ctl;
    assign read_data     = wb_q.rdata;
    assign wb_alu_result = wb_q.alu;
    assign wb_write_reg  = wb_q.dst;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        req_n   = mem_req;
        we_n    = mem_we;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        err_n   = 1'b0;
        wb_n    = '0;
        case (state)
            IDLE: begin
                if (memop) begin
                    state_n = ACCESS;
                    cnt_n   = '0;
                    req_n   = 1'b1;
                    we_n    = memwrite;
                    addr_n  = alu_result;
                    wdata_n = rdata2out;
                end else if (in_valid) begin
                    wb_n.valid = 1'b1;
                    wb_n.ctl   = wb_ctlout;
                    wb_n.alu   = alu_result;
                    wb_n.dst   = five_bit_muxout;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_n    = IDLE;
                    req_n      = 1'b0;
                    wb_n.valid = 1'b1;
                    wb_n.ctl   = wb_ctlout;
                    wb_n.rdata = mem_we ? '0 : mem_rdata;
                    wb_n.alu   = alu_result;
                    wb_n.dst   = five_bit_muxout;
                end else if (timeout) begin
                    // Retire without a register write so the pipeline keeps moving.
                    state_n    = IDLE;
                    req_n      = 1'b0;
                    err_n      = 1'b1;
                    wb_n.valid = 1'b1;
                    wb_n.alu   = alu_result;
                    wb_n.dst   = five_bit_muxout;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_err   <= 1'b0;
            wb_q      <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            mem_req   <= req_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            mem_err   <= err_n;
            wb_q      <= wb_n;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: table-driven single-cycle vectors plus hand-written memory sequences,
// with a retirement scoreboard checked whenever wb_valid is seen.
module tb_mem_wb_stage;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  wb_ctlout;
    logic        branch, memread, memwrite, zero;
    logic [31:0] add_result, alu_result, rdata2out;
    logic [4:0]  five_bit_muxout;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall, pcsrc;
    logic [31:0] branch_target;
    logic        mem_err, wb_valid;
    logic [1:0]  wb_ctl;
    logic [31:0] read_data, wb_alu_result;
    logic [4:0]  wb_write_reg;

    mem_wb_stage #(.DATA_W(32), .REG_W(5), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .wb_ctlout(wb_ctlout), .branch(branch),
        .memread(memread), .memwrite(memwrite), .add_result(add_result), .zero(zero),
        .alu_result(alu_result), .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall), .pcsrc(pcsrc),
        .branch_target(branch_target), .mem_err(mem_err), .wb_valid(wb_valid), .wb_ctl(wb_ctl),
        .read_data(read_data), .wb_alu_result(wb_alu_result), .wb_write_reg(wb_write_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ctl;
        logic [31:0] alu;
        logic [4:0]  dst;
        logic [31:0] rd;
        logic        chk_data;
    } ret_t;

    typedef struct {
        logic        v;
        logic [1:0]  ctl;
        logic        br, z;
        logic [31:0] add, alu;
        logic [4:0]  dst;
        logic        ack;
        logic        exp_pcsrc;
    } vec_t;

    ret_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every retirement must match the oldest expected record.
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_retire", 1, 0);
            end else begin
                ret_t e;
                e = exp_q.pop_front();
                check("ret_ctl", wb_ctl, e.ctl);
                if (e.chk_data) begin
                    check("ret_alu", wb_alu_result, e.alu);
                    check("ret_dst", wb_write_reg, e.dst);
                    check("ret_rdata", read_data, e.rd);
                end
            end
        end
    end

    task automatic bubble();
        in_valid = 0; wb_ctlout = 0; branch = 0; memread = 0; memwrite = 0; zero = 0;
        add_result = 0; alu_result = 0; rdata2out = 0; five_bit_muxout = 0;
        mem_ack = 0; mem_rdata = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one memop and handshakes; ack_after = ACCESS cycles before ack (>= TO means never).
    task automatic memop(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] ctl, input logic [4:0] dst,
                         input logic [31:0] rdata, input int ack_after);
        ret_t e;
        int   stall_cnt = 0, req_cnt = 0;
        logic done = 0;
        logic tmo = (ack_after >= TO);
        in_valid = 1; memread = rd; memwrite = wr; alu_result = addr; rdata2out = wdata;
        wb_ctlout = ctl; five_bit_muxout = dst;
        e.ctl = tmo ? 2'b00 : ctl; e.alu = addr; e.dst = dst;
        e.rd = wr ? 32'h0 : rdata; e.chk_data = !tmo;
        exp_q.push_back(e);
        for (int c = 0; c < 40 && !done; c++) begin
            if (mem_req) begin
                if (req_cnt == 0) begin
                    check("req_addr", mem_addr, addr);
                    check("req_we", mem_we, wr);
                    if (wr) check("req_wdata", mem_wdata, wdata);
                end
                if (req_cnt == ack_after) begin
                    mem_ack = 1; mem_rdata = rdata;
                end
                req_cnt++;
            end
            #1;
            if (stall) stall_cnt++;
            else done = 1;
            tick();
        end
        check("access_bounded", done, 1);
        bubble();
        check("stall_cycles", stall_cnt, tmo ? TO : ack_after + 1);
        check("req_cycles", req_cnt, tmo ? TO : ack_after + 1);
        check("req_dropped", mem_req, 0);
        check("mem_err_pulse", mem_err, tmo);
        tick();
        check("mem_err_clear", mem_err, 0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1, 2'b10, 0, 0, 32'h0,   32'h2A,       5,  0, 0};
        vecs[1] = '{0, 2'b11, 0, 1, 32'h55,  32'h77,       9,  0, 0};
        vecs[2] = '{1, 2'b00, 1, 1, 32'h100, 32'h0,        0,  0, 1};
        vecs[3] = '{1, 2'b00, 1, 0, 32'h100, 32'h1,        0,  0, 0};
        vecs[4] = '{0, 2'b00, 1, 1, 32'h100, 32'h0,        0,  0, 0};
        vecs[5] = '{1, 2'b11, 0, 1, 32'h200, 32'hFFFFFFFF, 31, 1, 0};
        vecs[6] = '{1, 2'b01, 0, 0, 32'hABC, 32'h80000000, 0,  1, 0};

        bubble();
        rst = 1;
        tick(); tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_ctl", wb_ctl, 0);
        check("rst_read_data", read_data, 0);
        check("rst_wb_alu", wb_alu_result, 0);
        check("rst_wb_reg", wb_write_reg, 0);
        rst = 0;

        foreach (vecs[i]) begin
            in_valid = vecs[i].v; wb_ctlout = vecs[i].ctl; branch = vecs[i].br; zero = vecs[i].z;
            add_result = vecs[i].add; alu_result = vecs[i].alu; five_bit_muxout = vecs[i].dst;
            mem_ack = vecs[i].ack;
            if (vecs[i].v) exp_q.push_back('{vecs[i].ctl, vecs[i].alu, vecs[i].dst, 32'h0, 1'b1});
            #1;
            check("vec_pcsrc", pcsrc, vecs[i].exp_pcsrc);
            check("vec_target", branch_target, vecs[i].add);
            check("vec_stall", stall, 0);
            tick();
            check("vec_wb_valid", wb_valid, vecs[i].v);
            check("vec_no_req", mem_req, 0);
        end
        bubble();
        tick();

        // lw, ack on the 4th ACCESS cycle
        memop(1, 0, 32'h40, 32'h0, 2'b11, 5'd7, 32'hDEADBEEF, 3);
        // sw with memread also set (write wins), immediate ack
        memop(1, 1, 32'h80, 32'h1234, 2'b00, 5'd0, 32'hFFFF0000, 0);
        // lw that never sees an ack
        memop(1, 0, 32'hC0, 32'h0, 2'b11, 5'd3, 32'h0, TO + 5);

        // reset on the 2nd ACCESS cycle discards the access
        in_valid = 1; memread = 1; alu_result = 32'h44; wb_ctlout = 2'b11; five_bit_muxout = 5'd2;
        tick();
        check("rst_seq_req", mem_req, 1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        bubble();
        check("midrst_req", mem_req, 0);
        check("midrst_addr", mem_addr, 0);
        check("midrst_wb_valid", wb_valid, 0);
        #1;
        check("midrst_stall", stall, 0);
        mem_ack = 1; mem_rdata = 32'h5A5A5A5A;
        tick();
        mem_ack = 0;
        check("late_ack_req", mem_req, 0);
        check("late_ack_wb_valid", wb_valid, 0);

        // post-reset ALU op still has latency 1
        in_valid = 1; wb_ctlout = 2'b10; alu_result = 32'h99; five_bit_muxout = 5'd12;
        exp_q.push_back('{2'b10, 32'h99, 5'd12, 32'h0, 1'b1});
        tick();
        bubble();
        check("post_rst_wb_valid", wb_valid, 1);
        tick(); tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
